mnist_frame_streamer: RTL and testbench
=======================================

Name: mnist_frame_streamer

Overview:
- Synthesizable stimulus/result engine for the MNIST classifier top.
- Stores up to NUM_IMG frames of NUM_PIX pixels each. On start, streams a batch of frames into the classifier pixel port using a valid/ready handshake.
- After each frame, waits for the classifier result, with a timeout, and records class and confidence per frame in a readable result bank.
- Replaces bench-only serial drivers and allows batch runs on hardware.

Parameters:
- PIX_W, 1, bits per pixel (1 = binarised MNIST).
- NUM_PIX, 784, pixels per frame.
- NUM_IMG, 4, frame slots in pixel memory.
- CLASS_W, 4, prediction width.
- CONF_W, 8, confidence width.
- TIMEOUT, 2000, max cycles from last pixel accepted to res_valid.
- Derived: AW = clog2(NUM_IMG*NUM_PIX); IW = clog2(NUM_IMG+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- load_we  in  1  pixel memory write strobe
- load_addr  in  AW  linear address: frame*NUM_PIX + pixel
- load_data  in  PIX_W  pixel value
- num_img  in  IW  frames to run, sampled at start
- start  in  1  begin batch (single-cycle strobe)
- busy  out  1  batch in progress
- done  out  1  one-cycle pulse at batch end
- pix_data  out  PIX_W  pixel to classifier
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  classifier accepts pixel
- res_class  in  CLASS_W  classifier prediction
- res_conf  in  CONF_W  classifier confidence
- res_valid  in  1  result strobe
- rd_idx  in  clog2(NUM_IMG)  result bank read index
- rd_class  out  CLASS_W  stored class (combinational read)
- rd_conf  out  CONF_W  stored confidence
- rd_vld  out  1  entry written this batch
- rd_tmo  out  1  entry ended by timeout
- tmo_count  out  IW  timeouts in current/last batch

Behaviour:
- Reset (synchronous, active low; clock clk):
  - state=IDLE; busy, done, pix_valid, tmo_count = 0; pix_data = 0; all rd_vld/rd_tmo bits = 0.
  - Pixel memory and class/conf storage are not reset.
- Pixel memory:
  - Written when load_we && !busy. load_we while busy is ignored.
  - A write and a read of the same address never overlap.
- FSM states: IDLE, FETCH, STREAM, WAIT_RES, NEXT, FIN.
- IDLE:
  - start=1 latches num_img (values > NUM_IMG are clamped to NUM_IMG) and clears all rd_vld, rd_tmo and tmo_count.
  - If num_img==0, go to FIN. Otherwise go to FETCH with frame=0 and pix=0.
  - start outside IDLE is ignored.
- FETCH: registered memory read of the first pixel, then go to STREAM. First pix_valid is high on the 2nd clock edge after start is sampled.
- STREAM:
  - pix_valid=1. pix_data is held stable while !pix_ready.
  - A beat is accepted when pix_valid && pix_ready.
  - Prefetch is required: with pix_ready tied high, one pixel is accepted per cycle, with no bubbles.
  - Acceptance of pixel NUM_PIX-1 → pix_valid=0 the next cycle; go to WAIT_RES; timer=0.
- WAIT_RES:
  - Timer increments each cycle.
  - res_valid=1 → store res_class/res_conf at [frame], set rd_vld, go to NEXT.
  - Timer reaching TIMEOUT-1 without res_valid → store class = all ones and conf = 0; set rd_vld and rd_tmo; tmo_count+1; go to NEXT.
  - If res_valid and the timeout coincide, the result wins and no timeout is counted.
  - res_valid in any other state is ignored.
- NEXT: frame+1. If it equals the latched num_img, go to FIN. Otherwise pix=0 and go to FETCH.
- FIN: done=1 for exactly one cycle; busy=0 the same cycle; go to IDLE.
- busy=1 in every state except IDLE and FIN.
- Counter widths: pixel counter clog2(NUM_PIX) bits, frame counter IW bits, timer clog2(TIMEOUT) bits. The pixel counter wraps to 0 only through the NEXT→FETCH path.
- Reset mid-batch: aborts immediately; next cycle all outputs hold their reset values; no done pulse is produced.

Optional Feature:
- Macro: MNIST_STREAM_CHECK_EN.
- When defined:
  - Extra inputs exp_we, exp_idx and exp_class write an expected-label bank.
  - Extra output err_count (IW bits) counts frames whose stored class differs from the expected label; timeouts count as errors. It is cleared on start.
  - Extra output pass is a one-cycle pulse together with done when err_count==0.
- When undefined: none of these ports or that logic exist; behaviour is otherwise identical.

Test Plan:
- Load frame0 as a digit-7 pattern; num_img=1; pix_ready=1; model answers class 7, conf 200, 30 cycles after the last pixel → exactly 784 beats in 784 consecutive cycles, first pix_valid 2 cycles after start, rd_idx=0 gives 7/200/vld=1/tmo=0, done pulses once.
- pix_ready toggled pseudo-randomly, 50% duty → 784 accepted beats, pix_data stable during every stall, accepted sequence equal to memory contents.
- num_img=3; model silent on frame 1 → frame 1 recorded as class 15/conf 0/tmo=1; tmo_count=1; frames 0 and 2 correct; done after frame 2.
- res_valid asserted on the exact timeout cycle → result stored with tmo=0 and tmo_count=0.
- Reset asserted at pixel 400 of frame 1 → next cycle busy=0, pix_valid=0, all rd_vld=0. A following start streams from frame 0, pixel 0.
- num_img=0 → done on the cycle after start, no pix_valid. start and load_we during busy are ignored; memory is unchanged.

Source files
------------

// File: rtl/mnist_frame_streamer.sv
// mnist_frame_streamer: stores NUM_IMG pixel frames, streams a batch of them to the
// classifier over a valid/ready port and records class/confidence (or timeout) per frame.
// Optional expected-label self-check (exp_* inputs, err_count, pass) is built only when
// the macro MNIST_STREAM_CHECK_EN is defined.
module mnist_frame_streamer #(
   parameter int PIX_W   = 1,
   parameter int NUM_PIX = 784,
   parameter int NUM_IMG = 4,
   parameter int CLASS_W = 4,
   parameter int CONF_W  = 8,
   parameter int TIMEOUT = 2000,
   localparam int AW = $clog2(NUM_IMG * NUM_PIX),
   localparam int IW = $clog2(NUM_IMG + 1),
   localparam int RW = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_we,
   input  logic [AW-1:0]      load_addr,
   input  logic [PIX_W-1:0]   load_data,
   input  logic [IW-1:0]      num_img,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [PIX_W-1:0]   pix_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   input  logic [CLASS_W-1:0] res_class,
   input  logic [CONF_W-1:0]  res_conf,
   input  logic               res_valid,
   input  logic [RW-1:0]      rd_idx,
`ifdef MNIST_STREAM_CHECK_EN
   input  logic               exp_we,
   input  logic [RW-1:0]      exp_idx,
   input  logic [CLASS_W-1:0] exp_class,
   output logic [IW-1:0]      err_count,
   output logic               pass,
`endif
   output logic [CLASS_W-1:0] rd_class,
   output logic [CONF_W-1:0]  rd_conf,
   output logic               rd_vld,
   output logic               rd_tmo,
   output logic [IW-1:0]      tmo_count
);

   localparam int DEPTH = NUM_IMG * NUM_PIX;
   localparam int NSLOT = 2 ** RW;
   localparam int PCW   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STREAM, S_WAIT_RES, S_NEXT, S_FIN} state_e;

   state_e             state_q, state_d;
   logic [IW-1:0]      frame_q, frame_d;
   logic [PCW-1:0]     pix_q, pix_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [IW-1:0]      num_q, num_d;
   logic [IW-1:0]      tmo_cnt_q, tmo_cnt_d;
   logic [NSLOT-1:0]   vld_q, vld_d;
   logic [NSLOT-1:0]   tmob_q, tmob_d;
   logic [PIX_W-1:0]   pix_data_q, pix_data_d;

   logic [PIX_W-1:0]   pix_mem  [DEPTH];
   logic [CLASS_W-1:0] cls_mem  [NSLOT];
   logic [CONF_W-1:0]  conf_mem [NSLOT];

   logic               rd_en;
   logic [PCW-1:0]     fetch_pix;
   logic [AW-1:0]      rd_addr;
   logic               res_we;
   logic               is_tmo;
   logic [CLASS_W-1:0] res_cls_w;
   logic [CONF_W-1:0]  res_conf_w;
   logic [RW-1:0]      slot;

`ifdef MNIST_STREAM_CHECK_EN
   logic [CLASS_W-1:0] exp_mem [NSLOT];
   logic [IW-1:0]      err_q, err_d;
`endif

   assign slot    = RW'(frame_q);
   assign rd_addr = AW'(frame_q) * AW'(NUM_PIX) + AW'(fetch_pix);

   // Next-state logic; the read address points one pixel ahead of the presented one
   // so that an accepted beat is replaced on the same edge (no bubbles).
   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      pix_d      = pix_q;
      timer_d    = timer_q;
      num_d      = num_q;
      tmo_cnt_d  = tmo_cnt_q;
      vld_d      = vld_q;
      tmob_d     = tmob_q;
      pix_data_d = pix_data_q;
      rd_en      = 1'b0;
      fetch_pix  = '0;
      res_we     = 1'b0;
      is_tmo     = 1'b0;
      res_cls_w  = res_class;
      res_conf_w = res_conf;
`ifdef MNIST_STREAM_CHECK_EN
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_d     = (num_img > IW'(NUM_IMG)) ? IW'(NUM_IMG) : num_img;
               vld_d     = '0;
               tmob_d    = '0;
               tmo_cnt_d = '0;
               frame_d   = '0;
               pix_d     = '0;
`ifdef MNIST_STREAM_CHECK_EN
               err_d     = '0;
`endif
               state_d   = (num_img == '0) ? S_FIN : S_FETCH;
            end
         end
         S_FETCH: begin
            rd_en   = 1'b1;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (pix_ready) begin
               if (pix_q == PCW'(NUM_PIX - 1)) begin
                  timer_d = '0;
                  state_d = S_WAIT_RES;
               end else begin
                  rd_en     = 1'b1;
                  fetch_pix = pix_q + PCW'(1);
                  pix_d     = pix_q + PCW'(1);
               end
            end
         end
         S_WAIT_RES: begin
            timer_d = timer_q + TW'(1);
            if (res_valid) begin
               res_we      = 1'b1;
               vld_d[slot] = 1'b1;
               state_d     = S_NEXT;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               res_we       = 1'b1;
               is_tmo       = 1'b1;
               res_cls_w    = '1;
               res_conf_w   = '0;
               vld_d[slot]  = 1'b1;
               tmob_d[slot] = 1'b1;
               tmo_cnt_d    = tmo_cnt_q + IW'(1);
               state_d      = S_NEXT;
            end
         end
         S_NEXT: begin
            frame_d = frame_q + IW'(1);
            if (frame_q + IW'(1) == num_q) begin
               state_d = S_FIN;
            end else begin
               pix_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (rd_en) pix_data_d = pix_mem[rd_addr];
`ifdef MNIST_STREAM_CHECK_EN
      if (res_we && (is_tmo || res_cls_w != exp_mem[slot])) err_d = err_q + IW'(1);
`endif
   end

   // Control/status registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         frame_q    <= '0;
         pix_q      <= '0;
         timer_q    <= '0;
         num_q      <= '0;
         tmo_cnt_q  <= '0;
         vld_q      <= '0;
         tmob_q     <= '0;
         pix_data_q <= '0;
`ifdef MNIST_STREAM_CHECK_EN
         err_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         pix_q      <= pix_d;
         timer_q    <= timer_d;
         num_q      <= num_d;
         tmo_cnt_q  <= tmo_cnt_d;
         vld_q      <= vld_d;
         tmob_q     <= tmob_d;
         pix_data_q <= pix_data_d;
`ifdef MNIST_STREAM_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

   // Pixel memory load port, locked out while a batch is running.
   always_ff @(posedge clk) begin
      if (load_we && !busy) pix_mem[load_addr] <= load_data;
   end

   // Per-frame result storage (not reset; validity is tracked in vld_q).
   always_ff @(posedge clk) begin
      if (res_we) begin
         cls_mem[slot]  <= res_cls_w;
         conf_mem[slot] <= res_conf_w;
      end
   end

`ifdef MNIST_STREAM_CHECK_EN
   // Expected-label bank written by the host.
   always_ff @(posedge clk) begin
      if (exp_we) exp_mem[exp_idx] <= exp_class;
   end

   assign err_count = err_q;
   assign pass      = (state_q == S_FIN) && (err_q == '0);
`endif

   assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done      = (state_q == S_FIN);
   assign pix_valid = (state_q == S_STREAM);
   assign pix_data  = pix_data_q;
   assign rd_class  = cls_mem[rd_idx];
   assign rd_conf   = conf_mem[rd_idx];
   assign rd_vld    = vld_q[rd_idx];
   assign rd_tmo    = tmob_q[rd_idx];
   assign tmo_count = tmo_cnt_q;

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// Scoreboard bench for mnist_frame_streamer: stimulus pushes expected beats and
// per-batch results; a monitor pops and compares when the DUT presents them.
module tb_mnist_frame_streamer;
   localparam int PIX_W   = 1;
   localparam int NUM_PIX = 784;
   localparam int NUM_IMG = 4;
   localparam int CLASS_W = 4;
   localparam int CONF_W  = 8;
   localparam int TIMEOUT = 2000;
   localparam int AW = $clog2(NUM_IMG * NUM_PIX);
   localparam int IW = $clog2(NUM_IMG + 1);
   localparam int RW = $clog2(NUM_IMG);

   logic               clk, rst_n, load_we, start, busy, done, pix_valid, pix_ready, res_valid;
   logic [AW-1:0]      load_addr;
   logic [PIX_W-1:0]   load_data, pix_data;
   logic [IW-1:0]      num_img, tmo_count;
   logic [CLASS_W-1:0] res_class, rd_class;
   logic [CONF_W-1:0]  res_conf, rd_conf;
   logic [RW-1:0]      rd_idx;
   logic               rd_vld, rd_tmo;

   mnist_frame_streamer #(.PIX_W(PIX_W), .NUM_PIX(NUM_PIX), .NUM_IMG(NUM_IMG),
                          .CLASS_W(CLASS_W), .CONF_W(CONF_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .num_img(num_img), .start(start), .busy(busy), .done(done),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .res_class(res_class), .res_conf(res_conf), .res_valid(res_valid), .rd_idx(rd_idx),
      .rd_class(rd_class), .rd_conf(rd_conf), .rd_vld(rd_vld), .rd_tmo(rd_tmo),
      .tmo_count(tmo_count));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      bit                 vld;
      bit                 tmo;
      logic [CLASS_W-1:0] cls;
      logic [CONF_W-1:0]  conf;
   } res_t;

   int checks = 0;
   int failures = 0;
   int beats_seen = 0;
   int dones_seen = 0;
   int dones_expected = 0;
   int ready_mode = 0;

   logic [PIX_W-1:0]   img [NUM_IMG][NUM_PIX];
   logic [PIX_W-1:0]   exp_pix_q [$];
   res_t               exp_res_q [$];
   int                 exp_tmo_q [$];
   int                 resp_delay [NUM_IMG];
   logic [CLASS_W-1:0] resp_cls [NUM_IMG];
   logic [CONF_W-1:0]  resp_conf [NUM_IMG];

   function automatic void check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic logic [PIX_W-1:0] seven(input int p);
      int r, c;
      r = p / 28;
      c = p % 28;
      return PIX_W'((r >= 4 && r <= 6 && c >= 6 && c <= 21) ||
                    (r >= 7 && r <= 23 && (c == 21 - (r - 7) / 2 || c == 20 - (r - 7) / 2)));
   endfunction

   // Classifier ready: always high, or a fair coin each cycle.
   initial begin
      pix_ready = 1'b0;
      forever begin
         @(negedge clk);
         pix_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Classifier model: after the last pixel of frame f, answers in cycle (last+1+delay),
   // or stays silent when the delay is negative.
   initial begin
      int cnt, f;
      cnt = 0; f = 0;
      res_valid = 1'b0; res_class = '0; res_conf = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst_n || !busy) begin
            cnt = 0; f = 0;
         end else if (pix_valid && pix_ready) begin
            cnt++;
            if (cnt == NUM_PIX) begin
               cnt = 0;
               if (f < NUM_IMG && resp_delay[f] >= 0) begin
                  repeat (resp_delay[f] + 1) @(negedge clk);
                  #1;
                  res_valid = 1'b1; res_class = resp_cls[f]; res_conf = resp_conf[f];
                  @(negedge clk); #1;
                  res_valid = 1'b0; res_class = CLASS_W'($urandom); res_conf = CONF_W'($urandom);
               end
               f++;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit prev_rst, prev_stall;
      logic [PIX_W-1:0] prev_data, e;
      res_t r;
      int et;
      prev_rst = 1'b1; prev_stall = 1'b0; prev_data = '0;
      rd_idx = '0;
      forever begin
         @(negedge clk); #1;
         if (rst_n && !prev_rst) begin
            check("rst_busy", busy, 0);
            check("rst_pix_valid", pix_valid, 0);
            check("rst_done", done, 0);
            check("rst_pix_data", pix_data, 0);
            check("rst_tmo_count", tmo_count, 0);
            for (int i = 0; i < NUM_IMG; i++) begin
               rd_idx = RW'(i); #1;
               check($sformatf("rst_rd_vld[%0d]", i), rd_vld, 0);
               check($sformatf("rst_rd_tmo[%0d]", i), rd_tmo, 0);
            end
         end
         if (rst_n) begin
            if (prev_stall) begin
               check("stall_valid", pix_valid, 1);
               check("stall_data", pix_data, prev_data);
            end
            if (pix_valid && pix_ready) begin
               beats_seen++;
               if (exp_pix_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_beat: got pixel %0d, required no beat (t=%0t)", pix_data, $time);
               end else begin
                  e = exp_pix_q.pop_front();
                  check("pixel", pix_data, e);
               end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            if (done) begin
               dones_seen++;
               check("done_busy", busy, 0);
               check("beats_left_at_done", exp_pix_q.size(), 0);
               if (exp_tmo_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_done: got done, required none (t=%0t)", $time);
               end else begin
                  et = exp_tmo_q.pop_front();
                  check("tmo_count", tmo_count, et);
                  for (int i = 0; i < NUM_IMG; i++) begin
                     r = exp_res_q.pop_front();
                     rd_idx = RW'(i); #1;
                     check($sformatf("rd_vld[%0d]", i), rd_vld, r.vld);
                     check($sformatf("rd_tmo[%0d]", i), rd_tmo, r.tmo);
                     if (r.vld) begin
                        check($sformatf("rd_class[%0d]", i), rd_class, r.cls);
                        check($sformatf("rd_conf[%0d]", i), rd_conf, r.conf);
                     end
                  end
               end
            end
         end else begin
            prev_stall = 1'b0;
         end
         prev_rst = rst_n;
      end
   end

   task automatic set_resp(input int f, input int d);
      resp_delay[f] = d;
      resp_cls[f]   = CLASS_W'($urandom_range(0, 9));
      resp_conf[f]  = CONF_W'($urandom);
   endtask

   task automatic load_px(input int f, input int p, input logic [PIX_W-1:0] v);
      @(negedge clk);
      load_we = 1'b1; load_addr = AW'(f * NUM_PIX + p); load_data = v;
      img[f][p] = v;
   endtask

   // mode: 0 ready high, 1 random ready, 2 ready high plus latency/burst checks.
   // abort_at >= 0: pulse reset once that many beats of the batch have been accepted.
   task automatic run_batch(input int num, input int mode, input int abort_at, input bit disturb);
      int n_eff, budget, lat, first_v, last_v, vcyc, b0, a;
      int tmo_exp;
      bit got;
      res_t r;
      n_eff = (num > NUM_IMG) ? NUM_IMG : num;
      for (int f = 0; f < n_eff; f++)
         for (int p = 0; p < NUM_PIX; p++) exp_pix_q.push_back(img[f][p]);
      if (abort_at < 0) begin
         tmo_exp = 0;
         for (int f = 0; f < NUM_IMG; f++) begin
            r.vld = (f < n_eff); r.tmo = 1'b0; r.cls = '0; r.conf = '0;
            if (f < n_eff) begin
               if (resp_delay[f] >= 0 && resp_delay[f] + 1 <= TIMEOUT) begin
                  r.cls = resp_cls[f]; r.conf = resp_conf[f];
               end else begin
                  r.tmo = 1'b1; r.cls = '1; r.conf = '0; tmo_exp++;
               end
            end
            exp_res_q.push_back(r);
         end
         exp_tmo_q.push_back(tmo_exp);
         dones_expected++;
      end
      ready_mode = mode;
      b0 = beats_seen;
      budget = n_eff * (NUM_PIX * 6 + TIMEOUT + 100) + 20;
      got = 1'b0; lat = -1; first_v = -1; last_v = -1; vcyc = 0;
      @(negedge clk);
      num_img = IW'(num); start = 1'b1;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
         if (pix_valid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            vcyc++;
         end
         if (disturb) begin
            if (cyc >= 100 && cyc <= 103) begin
               a = $urandom_range(0, NUM_IMG * NUM_PIX - 1);
               load_we = 1'b1; load_addr = AW'(a); load_data = ~img[a / NUM_PIX][a % NUM_PIX];
            end
            if (cyc == 104) load_we = 1'b0;
            if (cyc == 110) begin start = 1'b1; num_img = IW'(1); end
            if (cyc == 111) start = 1'b0;
         end
         if (abort_at >= 0 && beats_seen - b0 >= abort_at) begin
            exp_pix_q.delete();
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
            return;
         end
         if (done) begin
            got = 1'b1; lat = cyc;
            break;
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL done_wait: got no done, required done within %0d cycles", budget);
      end
      if (mode == 2) begin
         check("first_valid_latency", first_v, 2);
         check("valid_cycles", vcyc, NUM_PIX);
         check("valid_span", last_v - first_v + 1, NUM_PIX);
      end
      if (num == 0) begin
         check("empty_done_latency", lat, 1);
         check("empty_valid_cycles", vcyc, 0);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
      num_img = '0; start = 1'b0;
      for (int f = 0; f < NUM_IMG; f++) set_resp(f, 5);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int f = 0; f < NUM_IMG; f++)
         for (int p = 0; p < NUM_PIX; p++)
            load_px(f, p, (f == 0) ? seven(p) : PIX_W'($urandom_range(0, 1)));
      @(negedge clk);
      load_we = 1'b0;

      // Digit 7, one frame, back-to-back beats, answer 30 cycles after the last pixel.
      set_resp(0, 29); resp_cls[0] = 4'd7; resp_conf[0] = 8'd200;
      run_batch(1, 2, -1, 1'b0);

      // Three frames, classifier silent on frame 1.
      set_resp(0, $urandom_range(0, 60)); set_resp(1, -1); set_resp(2, $urandom_range(0, 60));
      run_batch(3, 0, -1, 1'b0);

      // Random back-pressure; also clears the previous batch's entries 1..2.
      set_resp(0, $urandom_range(0, 60));
      run_batch(1, 1, -1, 1'b0);

      // Result arrives on the very cycle the timeout would fire.
      set_resp(0, TIMEOUT - 1);
      run_batch(1, 0, -1, 1'b0);

      // Reset in the middle of frame 1, then a fresh batch from frame 0.
      set_resp(0, 10); set_resp(1, 10); set_resp(2, 10);
      run_batch(3, 0, NUM_PIX + 400, 1'b0);
      set_resp(0, $urandom_range(0, 60)); set_resp(1, $urandom_range(0, 60));
      run_batch(2, 0, -1, 1'b0);

      // Empty batch.
      run_batch(0, 0, -1, 1'b0);

      // Clamped count, late answer on frame 2, start and writes while busy.
      for (int f = 0; f < NUM_IMG; f++) set_resp(f, $urandom_range(0, 60));
      set_resp(2, TIMEOUT);
      run_batch(7, 1, -1, 1'b1);

      // Full re-read: memory must be untouched by the writes issued while busy.
      for (int f = 0; f < NUM_IMG; f++) set_resp(f, $urandom_range(0, 60));
      run_batch(4, 1, -1, 1'b0);

      check("done_count", dones_seen, dones_expected);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
